// File: rtl/snn_csr_router_if.sv
// Host and unit-side CSR bus for snn_csr_router.
// The master modport is the host/unit environment; the slave modport is the router.
interface snn_csr_router_if #(
    parameter int unsigned NUM_UNITS   = 2,
    parameter int unsigned ADDR_WIDTH  = 16,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned REGION_SIZE = 32'h1000,
    parameter int unsigned NUM_REGIONS = 4
);
    localparam int unsigned REGION_BITS = $clog2(NUM_REGIONS);
    localparam int unsigned OFFSET_BITS = $clog2(REGION_SIZE);

    logic                          req_valid;
    logic                          req_ready;
    logic                          req_write;
    logic [ADDR_WIDTH-1:0]         req_addr;
    logic [DATA_WIDTH-1:0]         req_wdata;
    logic                          rsp_valid;
    logic                          rsp_ready;
    logic [DATA_WIDTH-1:0]         rsp_rdata;
    logic                          rsp_err;
    logic [NUM_UNITS-1:0]          u_req_valid;
    logic [NUM_UNITS-1:0]          u_req_ready;
    logic                          u_req_write;
    logic [REGION_BITS-1:0]        u_req_region;
    logic [OFFSET_BITS-1:0]        u_req_offset;
    logic [DATA_WIDTH-1:0]         u_req_wdata;
    logic [NUM_UNITS-1:0]          u_rsp_valid;
    logic [NUM_UNITS*DATA_WIDTH-1:0] u_rsp_rdata;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready,
        output u_req_ready, u_rsp_valid, u_rsp_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  u_req_valid, u_req_write, u_req_region, u_req_offset, u_req_wdata
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
        input  u_req_ready, u_rsp_valid, u_rsp_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output u_req_valid, u_req_write, u_req_region, u_req_offset, u_req_wdata
    );
endinterface

// File: rtl/snn_csr_router.sv
// CSR router: decodes host addresses onto NUM_UNITS units, one transaction at a time,
// with decode-error and timeout responses and a saturating error counter.
module snn_csr_router #(
    parameter int unsigned NUM_UNITS      = 2,
    parameter int unsigned ADDR_WIDTH     = 16,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned UNIT_STRIDE    = 32'h6000,
    parameter int unsigned REGION_SIZE    = 32'h1000,
    parameter int unsigned NUM_REGIONS    = 4,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst,
    snn_csr_router_if.slave   bus,
    output logic [7:0]        err_count
);
    localparam int unsigned UNIT_BITS   = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
    localparam int unsigned REGION_BITS = $clog2(NUM_REGIONS);
    localparam int unsigned OFFSET_BITS = $clog2(REGION_SIZE);
    localparam int unsigned TMO_BITS    = $clog2(TIMEOUT_CYCLES) + 1;
    localparam int unsigned UNITS_END   = NUM_UNITS * UNIT_STRIDE;
    localparam int unsigned REGIONS_END = NUM_REGIONS * REGION_SIZE;

    typedef enum logic [1:0] {StIdle, StDispatch, StWaitRsp, StRespond} state_e;

    state_e                  state_q, state_d;
    logic                    write_q, write_d;
    logic [REGION_BITS-1:0]  region_q, region_d;
    logic [OFFSET_BITS-1:0]  offset_q, offset_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [UNIT_BITS-1:0]    unit_q, unit_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    err_q, err_d;
    logic [TMO_BITS-1:0]     tmo_q, tmo_d;
    logic [7:0]              err_count_q, err_count_d;

    logic [31:0]             addr_u, base_u, off_u;
    logic [UNIT_BITS-1:0]    dec_unit;
    logic                    dec_mapped;
    logic                    sel_req_ready, sel_rsp_valid, timeout;
    logic [DATA_WIDTH-1:0]   sel_rdata;

    // Unit select by constant threshold compares; region/offset are bit fields of the offset.
    always_comb begin
        addr_u   = 32'(bus.req_addr);
        dec_unit = '0;
        base_u   = '0;
        for (int unsigned k = 1; k < NUM_UNITS; k++) begin
            if (addr_u >= k * UNIT_STRIDE) begin
                dec_unit = UNIT_BITS'(k);
                base_u   = k * UNIT_STRIDE;
            end
        end
        off_u      = addr_u - base_u;
        dec_mapped = (addr_u < UNITS_END) && (off_u < REGIONS_END);
    end

    assign sel_req_ready = bus.u_req_ready[unit_q];
    assign sel_rsp_valid = bus.u_rsp_valid[unit_q];
    assign sel_rdata     = bus.u_rsp_rdata[unit_q*DATA_WIDTH +: DATA_WIDTH];
    assign timeout       = (tmo_q >= TMO_BITS'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d     = state_q;
        write_d     = write_q;
        region_d    = region_q;
        offset_d    = offset_q;
        wdata_d     = wdata_q;
        unit_d      = unit_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        tmo_d       = tmo_q;
        err_count_d = err_count_q;
        unique case (state_q)
            StIdle: begin
                if (bus.req_valid) begin
                    write_d  = bus.req_write;
                    region_d = REGION_BITS'(off_u >> OFFSET_BITS);
                    offset_d = OFFSET_BITS'(off_u);
                    wdata_d  = bus.req_wdata;
                    unit_d   = dec_unit;
                    tmo_d    = '0;
                    rdata_d  = '0;
                    err_d    = !dec_mapped;
                    state_d  = dec_mapped ? StDispatch : StRespond;
                end
            end
            StDispatch: begin
                tmo_d = tmo_q + TMO_BITS'(1);
                if (sel_req_ready) begin
                    state_d = StWaitRsp;
                end else if (timeout) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = StRespond;
                end
            end
            StWaitRsp: begin
                tmo_d = tmo_q + TMO_BITS'(1);
                // A response in the timeout cycle still completes normally.
                if (sel_rsp_valid) begin
                    rdata_d = write_q ? '0 : sel_rdata;
                    err_d   = 1'b0;
                    state_d = StRespond;
                end else if (timeout) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = StRespond;
                end
            end
            StRespond: begin
                if (bus.rsp_ready) begin
                    state_d = StIdle;
                    if (err_q && (err_count_q != 8'hFF)) err_count_d = err_count_q + 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            write_q     <= 1'b0;
            region_q    <= '0;
            offset_q    <= '0;
            wdata_q     <= '0;
            unit_q      <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            tmo_q       <= '0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            write_q     <= write_d;
            region_q    <= region_d;
            offset_q    <= offset_d;
            wdata_q     <= wdata_d;
            unit_q      <= unit_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            tmo_q       <= tmo_d;
            err_count_q <= err_count_d;
        end
    end

    // req_ready is gated by rst so every output reads 0 while reset is held.
    always_comb begin
        bus.req_ready   = (state_q == StIdle) && !rst;
        bus.u_req_valid = '0;
        if (state_q == StDispatch) bus.u_req_valid[unit_q] = 1'b1;
    end

    assign bus.rsp_valid    = (state_q == StRespond);
    assign bus.rsp_rdata    = rdata_q;
    assign bus.rsp_err      = err_q;
    assign bus.u_req_write  = write_q;
    assign bus.u_req_region = region_q;
    assign bus.u_req_offset = offset_q;
    assign bus.u_req_wdata  = wdata_q;
    assign err_count        = err_count_q;
endmodule
